// File: rtl/mon_i2c_sampled.sv
// -----------------------------------------------------------------------------
// mon_i2c_sampled
//
// Clocked I2C bus monitor. SCL and SDA are synchronised onto i_clk, then
// START, STOP and data-bit events are decoded. Each event is queued in a small
// first-word-fall-through FIFO that the consumer drains with a pop strobe.
// Bus phase durations are measured in clock cycles and compared against
// programmable minimums. Violations latch into sticky flags.
//
// Ports
//   i_clk              sole clock
//   i_rst              asynchronous reset, active high
//   i_scl, i_sda       raw bus lines (asynchronous to i_clk)
//   i_en_timing_check  allows the violation flags to be set
//   i_clr_all          synchronous clear of FIFO, counters, flags, decoder
//   i_t_low            minimum SCL low/high, bus free, START/STOP setup/hold
//   i_t_su             minimum data setup (SDA change to SCL rise)
//   i_pop              consume the head event
//   o_evt_valid        FIFO not empty
//   o_evt              head event code (2'b00 when empty)
//   o_fifo_cnt         FIFO occupancy
//   o_overflow         sticky: an event was dropped on a full FIFO
//   o_num_events       detected events, saturating
//   o_t_low_err        sticky: a phase was shorter than i_t_low
//   o_t_su_err         sticky: data setup was shorter than i_t_su
//   o_bus_busy         high between START and STOP
//
// Event handshake: an entry is consumed on a rising clock edge where both
// o_evt_valid and i_pop are high. i_pop while o_evt_valid is low is ignored.
// o_evt is stable while o_evt_valid is high and no pop is taken.
// -----------------------------------------------------------------------------
module mon_i2c_sampled #(
   parameter int         CNT_W           = 16,
   parameter int         FIFO_DEPTH      = 16,
   parameter int         SYNC_STAGES     = 2,
   parameter logic [1:0] DEF_MON_EVENT_0 = 2'b00,
   parameter logic [1:0] DEF_MON_EVENT_1 = 2'b01,
   parameter logic [1:0] DEF_MON_EVENT_P = 2'b10,
   parameter logic [1:0] DEF_MON_EVENT_S = 2'b11
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_scl,
   input  logic                          i_sda,
   input  logic                          i_en_timing_check,
   input  logic                          i_clr_all,
   input  logic [CNT_W-1:0]              i_t_low,
   input  logic [CNT_W-1:0]              i_t_su,
   input  logic                          i_pop,
   output logic                          o_evt_valid,
   output logic [1:0]                    o_evt,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
   output logic                          o_overflow,
   output logic [31:0]                   o_num_events,
   output logic                          o_t_low_err,
   output logic                          o_t_su_err,
   output logic                          o_bus_busy
);

   localparam int               AW       = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [31:0]      NUM_MAX  = 32'hFFFF_FFFF;

   // ---------------------------------------------------------------------------
   // Synchronisers and previous-sample flops. They reset to 1 (idle bus) and are
   // deliberately left untouched by i_clr_all so that a clear never fabricates
   // a bus edge.
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   sda_s;
   logic                   scl_p;
   logic                   sda_p;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_p    <= 1'b1;
         sda_p    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
         scl_p    <= scl_s;
         sda_p    <= sda_s;
      end
   end

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   // ---------------------------------------------------------------------------
   // Event decode (combinational, every cycle)
   // ---------------------------------------------------------------------------
   logic scl_rise;
   logic scl_fall;
   logic scl_hi_stable;
   logic sda_chg;
   logic sda_chg_low;
   logic det_start;
   logic det_stop;
   logic det_bit;
   logic ph_evt;
   logic psbl_data;

   assign scl_rise      = ~scl_p &  scl_s;
   assign scl_fall      =  scl_p & ~scl_s;
   assign scl_hi_stable =  scl_p &  scl_s;
   assign sda_chg       =  sda_p ^  sda_s;

   // START/STOP need SCL high in both samples, so an SDA change coinciding with
   // an SCL edge is never a START/STOP and is treated as an SDA change while
   // SCL is low.
   assign det_start   = scl_hi_stable &  sda_p & ~sda_s;
   assign det_stop    = scl_hi_stable & ~sda_p &  sda_s;
   assign sda_chg_low = sda_chg & ~scl_hi_stable;

   // A data bit exists only if SCL rose since the last START/STOP/fall. sda_p
   // is the SDA value held during the high phase, even if SDA moves together
   // with the falling edge.
   assign det_bit = scl_fall & psbl_data;

   // Events that restart the phase counter.
   assign ph_evt = scl_rise | scl_fall | det_start | det_stop;

   logic       push_d;
   logic [1:0] code_d;

   always_comb begin
      push_d = 1'b0;
      code_d = DEF_MON_EVENT_0;
      if (det_start) begin
         push_d = 1'b1;
         code_d = DEF_MON_EVENT_S;
      end else if (det_stop) begin
         push_d = 1'b1;
         code_d = DEF_MON_EVENT_P;
      end else if (det_bit) begin
         push_d = 1'b1;
         code_d = sda_p ? DEF_MON_EVENT_1 : DEF_MON_EVENT_0;
      end
   end

   // ---------------------------------------------------------------------------
   // Timing counters and checks.
   // A counter holds n in the cycle that lies n cycles after its restarting
   // event. A restart therefore loads 1, and the check in the restart cycle
   // still sees the interval since the previous event.
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] ph_cnt;
   logic [CNT_W-1:0] su_cnt;
   logic [CNT_W-1:0] su_elapsed;
   logic             low_viol;
   logic             su_viol;

   // An SDA change in the same cycle as an SCL rise has zero setup time.
   assign su_elapsed = sda_chg_low ? '0 : su_cnt;
   assign low_viol   = ph_evt   & (ph_cnt < i_t_low);
   assign su_viol    = scl_rise & (su_elapsed < i_t_su);

   // ---------------------------------------------------------------------------
   // Decoder state, registered push, timing counters and sticky flags
   // ---------------------------------------------------------------------------
   logic       push_q;
   logic [1:0] code_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         psbl_data   <= 1'b0;
         o_bus_busy  <= 1'b0;
         push_q      <= 1'b0;
         code_q      <= DEF_MON_EVENT_0;
         ph_cnt      <= CNT_MAX;
         su_cnt      <= CNT_MAX;
         o_t_low_err <= 1'b0;
         o_t_su_err  <= 1'b0;
      end else if (i_clr_all) begin
         // Anything detected in the clear cycle is discarded with the rest.
         psbl_data   <= 1'b0;
         o_bus_busy  <= 1'b0;
         push_q      <= 1'b0;
         code_q      <= DEF_MON_EVENT_0;
         ph_cnt      <= CNT_MAX;
         su_cnt      <= CNT_MAX;
         o_t_low_err <= 1'b0;
         o_t_su_err  <= 1'b0;
      end else begin
         push_q <= push_d;
         code_q <= code_d;

         if (det_start) begin
            o_bus_busy <= 1'b1;
         end else if (det_stop) begin
            o_bus_busy <= 1'b0;
         end

         if (det_start || det_stop) begin
            psbl_data <= 1'b0;
         end else if (scl_rise) begin
            psbl_data <= 1'b1;
         end else if (scl_fall) begin
            psbl_data <= 1'b0;
         end

         if (ph_evt) begin
            ph_cnt <= CNT_W'(1);
         end else if (ph_cnt != CNT_MAX) begin
            ph_cnt <= ph_cnt + CNT_W'(1);
         end

         if (sda_chg_low) begin
            su_cnt <= CNT_W'(1);
         end else if (su_cnt != CNT_MAX) begin
            su_cnt <= su_cnt + CNT_W'(1);
         end

         if (i_en_timing_check && low_viol) begin
            o_t_low_err <= 1'b1;
         end
         if (i_en_timing_check && su_viol) begin
            o_t_su_err <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Event FIFO (first word fall through)
   // ---------------------------------------------------------------------------
   logic [1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          fifo_empty;
   logic          fifo_full;
   logic          pop_ok;
   logic          wr_ok;
   logic          drop;

   assign fifo_empty = (o_fifo_cnt == '0);
   assign fifo_full  = (o_fifo_cnt == FULL_CNT);
   assign pop_ok     = i_pop & ~fifo_empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign wr_ok      = push_q & (~fifo_full | pop_ok);
   assign drop       = push_q &  fifo_full & ~pop_ok;

   always_ff @(posedge i_clk) begin
      if (wr_ok && !i_clr_all) begin
         mem[wr_ptr] <= code_q;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         o_fifo_cnt   <= '0;
         o_overflow   <= 1'b0;
         o_num_events <= '0;
      end else if (i_clr_all) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         o_fifo_cnt   <= '0;
         o_overflow   <= 1'b0;
         o_num_events <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end

         case ({wr_ok, pop_ok})
            2'b10:   o_fifo_cnt <= o_fifo_cnt + (AW+1)'(1);
            2'b01:   o_fifo_cnt <= o_fifo_cnt - (AW+1)'(1);
            default: o_fifo_cnt <= o_fifo_cnt;
         endcase

         if (drop) begin
            o_overflow <= 1'b1;
         end

         // Dropped events are still counted as detected.
         if (push_q && (o_num_events != NUM_MAX)) begin
            o_num_events <= o_num_events + 32'd1;
         end
      end
   end

   assign o_evt_valid = ~fifo_empty;
   assign o_evt       = fifo_empty ? DEF_MON_EVENT_0 : mem[rd_ptr];

endmodule

// File: tb/tb_mon_i2c_sampled.sv
module tb_mon_i2c_sampled;

   localparam logic [1:0] EV_0 = 2'b00;
   localparam logic [1:0] EV_1 = 2'b01;
   localparam logic [1:0] EV_P = 2'b10;
   localparam logic [1:0] EV_S = 2'b11;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        scl;
   logic        sda;
   logic        en;
   logic        clr;
   logic        pop;
   logic        pop4;
   logic [15:0] t_low;
   logic [15:0] t_su;

   logic        evt_valid;
   logic [1:0]  evt;
   logic [4:0]  fifo_cnt;
   logic        overflow;
   logic [31:0] num_events;
   logic        low_err;
   logic        su_err;
   logic        busy;

   logic        evt_valid4;
   logic [1:0]  evt4;
   logic [2:0]  fifo_cnt4;
   logic        overflow4;
   logic [31:0] num_events4;
   logic        low_err4;
   logic        su_err4;
   logic        busy4;

   mon_i2c_sampled dut (
      .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_sda(sda),
      .i_en_timing_check(en), .i_clr_all(clr), .i_t_low(t_low), .i_t_su(t_su),
      .i_pop(pop), .o_evt_valid(evt_valid), .o_evt(evt), .o_fifo_cnt(fifo_cnt),
      .o_overflow(overflow), .o_num_events(num_events), .o_t_low_err(low_err),
      .o_t_su_err(su_err), .o_bus_busy(busy)
   );

   mon_i2c_sampled #(.FIFO_DEPTH(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_sda(sda),
      .i_en_timing_check(en), .i_clr_all(clr), .i_t_low(t_low), .i_t_su(t_su),
      .i_pop(pop4), .o_evt_valid(evt_valid4), .o_evt(evt4), .o_fifo_cnt(fifo_cnt4),
      .o_overflow(overflow4), .o_num_events(num_events4), .o_t_low_err(low_err4),
      .o_t_su_err(su_err4), .o_bus_busy(busy4)
   );

   // ---------------------------------------------------------------- scoreboard
   int         total = 0;
   int         bad   = 0;
   logic [1:0] exp_q[$];
   logic [1:0] exp4_q[$];
   int         num_exp = 0;
   logic       ov4_exp = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model of both FIFOs: the 16-deep one keeps everything, the 4-deep one
   // drops once it holds 4 (valid while no pop overlaps the push).
   function automatic void expect_evt(input logic [1:0] c);
      exp_q.push_back(c);
      num_exp++;
      if (exp4_q.size() < 4) exp4_q.push_back(c);
      else ov4_exp = 1'b1;
   endfunction

   function automatic void model_clear();
      exp_q.delete();
      exp4_q.delete();
      num_exp = 0;
      ov4_exp = 1'b0;
   endfunction

   // ---------------------------------------------------------------- drivers
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      model_clear();
      step(1);
   endtask

   task automatic bus_start();
      sda = 1'b0;
      expect_evt(EV_S);
      step(20);
   endtask

   // SCL falls, SDA set after a cycles, SCL rises c cycles later, high for h.
   // The bit is reported by the DUT on the following fall.
   task automatic bus_bit(input logic b, input int a, input int c, input int h);
      scl = 1'b0;
      step(a);
      sda = b;
      step(c);
      scl = 1'b1;
      expect_evt(b ? EV_1 : EV_0);
      step(h);
   endtask

   task automatic bus_stop_pre();
      scl = 1'b0;
      step(20);
      sda = 1'b0;
      step(20);
      scl = 1'b1;
      step(20);
   endtask

   task automatic bus_stop();
      bus_stop_pre();
      sda = 1'b1;
      expect_evt(EV_P);
      step(20);
   endtask

   task automatic drain16(input string tag);
      logic [1:0] e;
      for (int g = 0; g < 40 && evt_valid; g++) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " evt"}, 32'(evt), 32'(e));
         end else begin
            check({tag, " extra evt"}, 32'(evt_valid), 32'd0);
         end
         pop = 1'b1;
         step(1);
         pop = 1'b0;
      end
      check({tag, " sb left"}, 32'(exp_q.size()), 32'd0);
      check({tag, " cnt"}, 32'(fifo_cnt), 32'd0);
   endtask

   task automatic drain4(input string tag);
      logic [1:0] e;
      for (int g = 0; g < 20 && evt_valid4; g++) begin
         if (exp4_q.size() > 0) begin
            e = exp4_q.pop_front();
            check({tag, " evt4"}, 32'(evt4), 32'(e));
         end else begin
            check({tag, " extra evt4"}, 32'(evt_valid4), 32'd0);
         end
         pop4 = 1'b1;
         step(1);
         pop4 = 1'b0;
      end
      check({tag, " sb4 left"}, 32'(exp4_q.size()), 32'd0);
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic        en;
      int          a;
      int          c;
      logic [15:0] tsu;
      logic        exp_low;
      logic        exp_su;
   } tvec_t;

   tvec_t tv [10];

   // ---------------------------------------------------------------- test
   initial begin
      // t_low = 10 throughout; SCL low time is a+c, data setup is c.
      tv[0] = '{1'b1,  4, 4, 16'd4, 1'b1, 1'b0};
      tv[1] = '{1'b1, 18, 2, 16'd4, 1'b0, 1'b1};
      tv[2] = '{1'b0,  4, 4, 16'd4, 1'b0, 1'b0};
      tv[3] = '{1'b0, 18, 2, 16'd4, 1'b0, 1'b0};
      tv[4] = '{1'b1,  6, 4, 16'd4, 1'b0, 1'b0};
      tv[5] = '{1'b1,  5, 4, 16'd4, 1'b1, 1'b0};
      tv[6] = '{1'b1,  7, 3, 16'd4, 1'b0, 1'b1};
      tv[7] = '{1'b1,  2, 2, 16'd4, 1'b1, 1'b1};
      tv[8] = '{1'b1, 10, 0, 16'd4, 1'b0, 1'b1};
      tv[9] = '{1'b1, 10, 0, 16'd0, 1'b0, 1'b0};

      rst = 1'b1; scl = 1'b1; sda = 1'b1; en = 1'b0; clr = 1'b0;
      pop = 1'b0; pop4 = 1'b0; t_low = 16'd10; t_su = 16'd4;
      step(3);
      rst = 1'b0;
      step(2);

      // Reset state
      check("rst valid", 32'(evt_valid), 32'd0);
      check("rst evt", 32'(evt), 32'd0);
      check("rst cnt", 32'(fifo_cnt), 32'd0);
      check("rst ovf", 32'(overflow), 32'd0);
      check("rst num", num_events, 32'd0);
      check("rst low_err", 32'(low_err), 32'd0);
      check("rst su_err", 32'(su_err), 32'd0);
      check("rst busy", 32'(busy), 32'd0);

      // Basic decode: S 1 0 1 P, latency of the first event
      sda = 1'b0;
      expect_evt(EV_S);
      step(2);
      check("busy before S seen", 32'(busy), 32'd0);
      step(1);
      check("valid at +3", 32'(evt_valid), 32'd0);
      check("busy after S", 32'(busy), 32'd1);
      step(1);
      check("valid at +4", 32'(evt_valid), 32'd1);
      step(16);
      bus_bit(1'b1, 10, 10, 20);
      bus_bit(1'b0, 10, 10, 20);
      bus_bit(1'b1, 10, 10, 20);
      check("busy mid frame", 32'(busy), 32'd1);
      bus_stop();
      check("busy after P", 32'(busy), 32'd0);
      check("basic num", num_events, 32'd5);
      check("basic cnt", 32'(fifo_cnt), 32'd5);
      check("basic cnt4", 32'(fifo_cnt4), 32'd4);
      check("basic ovf4", 32'(overflow4), 32'(ov4_exp));
      check("basic num4", num_events4, 32'(num_exp));
      drain16("basic");

      // Overflow on the 4-deep instance: 6 events, no pops
      do_clr();
      bus_start();
      bus_bit(1'b1, 10, 10, 20);
      bus_bit(1'b0, 10, 10, 20);
      bus_bit(1'b0, 10, 10, 20);
      bus_bit(1'b1, 10, 10, 20);
      bus_stop();
      check("ovf cnt4", 32'(fifo_cnt4), 32'd4);
      check("ovf flag4", 32'(overflow4), 32'(ov4_exp));
      check("ovf num4", num_events4, 32'd6);
      check("ovf flag16", 32'(overflow), 32'd0);
      drain4("ovf");
      drain16("ovf16");

      // Full FIFO with push and pop in the same cycle
      do_clr();
      bus_start();
      bus_bit(1'b1, 10, 10, 20);
      bus_bit(1'b0, 10, 10, 20);
      bus_bit(1'b1, 10, 10, 20);
      bus_stop_pre();
      check("fpp cnt4 full", 32'(fifo_cnt4), 32'd4);
      sda = 1'b1;                       // STOP: written 4 edges later
      step(3);
      check("fpp head", 32'(evt4), 32'(exp4_q.pop_front()));
      expect_evt(EV_P);
      pop4 = 1'b1;
      step(1);
      pop4 = 1'b0;
      check("fpp cnt4", 32'(fifo_cnt4), 32'd4);
      check("fpp ovf4", 32'(overflow4), 32'd0);
      step(20);
      check("fpp cnt4 later", 32'(fifo_cnt4), 32'd4);
      check("fpp ovf4 later", 32'(overflow4), 32'd0);
      drain4("fpp");
      drain16("fpp16");

      // Timing-check table
      for (int i = 0; i < 10; i++) begin
         t_low = 16'd10;
         t_su  = tv[i].tsu;
         en    = tv[i].en;
         do_clr();
         bus_start();
         bus_bit(1'b1, tv[i].a, tv[i].c, 20);
         bus_stop();
         check($sformatf("tv%0d low_err", i), 32'(low_err), 32'(tv[i].exp_low));
         check($sformatf("tv%0d su_err", i), 32'(su_err), 32'(tv[i].exp_su));
         check($sformatf("tv%0d num", i), num_events, 32'(num_exp));
         drain16($sformatf("tv%0d", i));
      end

      // Clear during traffic: 3 queued, low_err set, STOP push coincides with clear
      t_low = 16'd10; t_su = 16'd4; en = 1'b1;
      do_clr();
      bus_start();
      bus_bit(1'b1, 4, 4, 20);
      bus_bit(1'b0, 10, 10, 20);
      bus_stop_pre();
      check("clr pre cnt", 32'(fifo_cnt), 32'd3);
      check("clr pre low_err", 32'(low_err), 32'd1);
      sda = 1'b1;
      step(3);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      model_clear();
      check("clr cnt", 32'(fifo_cnt), 32'd0);
      check("clr num", num_events, 32'd0);
      check("clr low_err", 32'(low_err), 32'd0);
      check("clr valid", 32'(evt_valid), 32'd0);
      check("clr busy", 32'(busy), 32'd0);
      step(10);
      check("clr push lost", 32'(fifo_cnt), 32'd0);
      check("clr num later", num_events, 32'd0);

      // Reset mid-byte, released with SCL low
      en = 1'b0;
      do_clr();
      bus_start();
      scl = 1'b0;
      step(10);
      sda = 1'b1;
      step(10);
      scl = 1'b1;
      step(8);
      check("pre-rst cnt", 32'(fifo_cnt), 32'd1);
      rst = 1'b1;
      #1;
      check("mid rst valid", 32'(evt_valid), 32'd0);
      check("mid rst cnt", 32'(fifo_cnt), 32'd0);
      check("mid rst num", num_events, 32'd0);
      check("mid rst busy", 32'(busy), 32'd0);
      model_clear();
      scl = 1'b0;
      step(3);
      rst = 1'b0;
      step(20);
      check("post rst fall cnt", 32'(fifo_cnt), 32'd0);
      check("post rst fall num", num_events, 32'd0);
      check("post rst busy", 32'(busy), 32'd0);
      sda = 1'b0;
      step(10);
      scl = 1'b1;
      step(20);
      scl = 1'b0;
      expect_evt(EV_0);
      step(20);
      check("post rst bit cnt", 32'(fifo_cnt), 32'd1);
      check("post rst bit num", num_events, 32'd1);
      drain16("post rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
